mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_wait_timer.sv | 32 +++
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int         DEFAULT_TIMEOUT = 255;
  localparam logic [3:0] BE_ALL          = 4'hF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    IF_BUSY    = 2'd1,
    DM_BUSY    = 2'd2,
    IF_DISCARD = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } grant_owner_t;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Wait-state counter: counts cycles a command waits for mem_ready and flags
// the cycle in which the TIMEOUT-th wait is reached.
module wait_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_r;
  logic [7:0] last_wait_s;

  // expired fires during the wait cycle that brings the count up to limit
  assign last_wait_s = limit - 8'd1;
  assign expired     = enable & (count_r == last_wait_s);

  // Wait-cycle counter, cleared whenever the arbiter is idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable && !expired) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage and the memory stage.
// One transaction outstanding at a time; fetch/data alternate under contention.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

  arb_state_t   state_r, state_nxt_s;
  grant_owner_t last_grant_r;

  logic if_elig_s, dm_elig_s;
  logic grant_if_s, grant_dm_s;
  logic finish_if_s, finish_dm_s, timeout_s;
  logic expired_s;

  // A requester whose pulse is showing this cycle is the one just served,
  // so it is not eligible again until its pulse is gone.
  assign if_stall  = if_req & ~if_valid;
  assign dm_stall  = dm_req & ~dm_done;
  assign if_elig_s = if_stall & ~if_flush;
  assign dm_elig_s = dm_stall;

  wait_timer u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_r == IDLE),
    .enable  (mem_req & ~mem_ready),
    .limit   (TIMEOUT_LIMIT),
    .expired (expired_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, grant selection and completion decode
  always_comb begin
    state_nxt_s = state_r;
    grant_if_s  = 1'b0;
    grant_dm_s  = 1'b0;
    finish_if_s = 1'b0;
    finish_dm_s = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_elig_s && (last_grant_r == OWN_DM || !dm_elig_s)) begin
          grant_if_s  = 1'b1;
          state_nxt_s = IF_BUSY;
        end else if (dm_elig_s) begin
          grant_dm_s  = 1'b1;
          state_nxt_s = DM_BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IF_BUSY: begin
        if (mem_ready) begin
          finish_if_s = ~if_flush;
          state_nxt_s = IDLE;
        end else if (expired_s) begin
          finish_if_s = ~if_flush;
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (if_flush) begin
          state_nxt_s = IF_DISCARD;
        end else begin
          state_nxt_s = IF_BUSY;
        end
      end
      DM_BUSY: begin
        if (mem_ready) begin
          finish_dm_s = 1'b1;
          state_nxt_s = IDLE;
        end else if (expired_s) begin
          finish_dm_s = 1'b1;
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DM_BUSY;
        end
      end
      IF_DISCARD: begin
        if (mem_ready) begin
          state_nxt_s = IDLE;
        end else if (expired_s) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IF_DISCARD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Memory command, return data, pulses and last-grant history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_be       <= 4'd0;
      if_rdata     <= 32'd0;
      dm_rdata     <= 32'd0;
      if_valid     <= 1'b0;
      dm_done      <= 1'b0;
      bus_err      <= 1'b0;
      last_grant_r <= OWN_IF;
    end else begin
      mem_req  <= (state_nxt_s != IDLE);
      if_valid <= finish_if_s;
      dm_done  <= finish_dm_s;
      bus_err  <= timeout_s;

      if (grant_if_s) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= 32'd0;
        mem_be    <= BE_ALL;
      end else if (grant_dm_s) begin
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_be    <= dm_we ? dm_be : BE_ALL;
      end else begin
        mem_we    <= mem_we;
        mem_addr  <= mem_addr;
        mem_wdata <= mem_wdata;
        mem_be    <= mem_be;
      end

      // aborted transactions return zero rather than whatever is on the bus
      if (finish_if_s) begin
        if_rdata <= timeout_s ? 32'd0 : mem_rdata;
      end else begin
        if_rdata <= if_rdata;
      end

      if (finish_dm_s) begin
        dm_rdata <= timeout_s ? 32'd0 : mem_rdata;
      end else begin
        dm_rdata <= dm_rdata;
      end

      if (grant_if_s) begin
        last_grant_r <= OWN_IF;
      end else if (grant_dm_s) begin
        last_grant_r <= OWN_DM;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT = 4). Inputs change and outputs are
// checked 1 ns after each rising edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] dm_addr = 32'd0, dm_wdata = 32'd0;
  logic [3:0]  dm_be = 4'd0;
  logic [31:0] dm_rdata;
  logic        dm_done, dm_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        bus_err;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    check("rst_mem_req", mem_req, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", mem_be, 32'd0);
    check("rst_if_valid", if_valid, 32'd0);
    check("rst_dm_done", dm_done, 32'd0);
    check("rst_bus_err", bus_err, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    reset = 1'b0;

    // ---------------- fetch only ----------------
    if_req = 1'b1; if_addr = 32'h0;
    #1 check("f_stall_n", if_stall, 32'd1);
    tick();
    check("f_mem_req", mem_req, 32'd1);
    check("f_mem_addr", mem_addr, 32'h0);
    check("f_mem_we", mem_we, 32'd0);
    check("f_mem_be", mem_be, 32'hF);
    check("f_valid_n1", if_valid, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h00500093;
    tick();
    check("f_valid_n2", if_valid, 32'd1);
    check("f_rdata", if_rdata, 32'h00500093);
    check("f_mem_req_drop", mem_req, 32'd0);
    check("f_stall_n2", if_stall, 32'd0);
    mem_ready = 1'b0; if_req = 1'b0;
    tick();
    check("f_valid_n3", if_valid, 32'd0);
    check("f_idle", mem_req, 32'd0);

    // ---------------- contention right after reset ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    #1 check("c_if_stall0", if_stall, 32'd1);
    tick();
    check("c_dm_first", mem_addr, 32'h100);
    check("c_dm_we", mem_we, 32'd0);
    check("c_dm_be", mem_be, 32'hF);
    check("c_if_stall1", if_stall, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h11112222;
    tick();
    check("c_dm_done", dm_done, 32'd1);
    check("c_dm_rdata", dm_rdata, 32'h11112222);
    check("c_if_stall2", if_stall, 32'd1);
    check("c_dm_stall", dm_stall, 32'd0);
    dm_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("c_if_grant", mem_req, 32'd1);
    check("c_if_addr", mem_addr, 32'h4);
    check("c_dm_done_one", dm_done, 32'd0);
    check("c_if_stall3", if_stall, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h33334444;
    tick();
    check("c_if_valid", if_valid, 32'd1);
    check("c_if_rdata", if_rdata, 32'h33334444);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    // ---------------- store with two wait states ----------------
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011;
    dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("s_mem_req", mem_req, 32'd1);
      check("s_mem_we", mem_we, 32'd1);
      check("s_mem_addr", mem_addr, 32'h200);
      check("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("s_mem_be", mem_be, 32'h3);
      check("s_no_done", dm_done, 32'd0);
      if (i == 2) mem_ready = 1'b1;
      tick();
    end
    check("s_done", dm_done, 32'd1);
    check("s_mem_req_drop", mem_req, 32'd0);
    dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    tick();
    check("s_done_one", dm_done, 32'd0);

    // ---------------- last grant was data: fetch wins contention ----------------
    if_req = 1'b1; if_addr = 32'hC;
    dm_req = 1'b1; dm_addr = 32'h400;
    tick();
    check("p_if_wins", mem_addr, 32'hC);
    check("p_if_we", mem_we, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA5555;
    tick();
    check("p_if_valid", if_valid, 32'd1);
    check("p_if_rdata", if_rdata, 32'hAAAA5555);
    check("p_dm_stall", dm_stall, 32'd1);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("p_dm_grant", mem_addr, 32'h400);
    check("p_dm_req", mem_req, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    tick();
    check("p_dm_done", dm_done, 32'd1);
    check("p_dm_rdata", dm_rdata, 32'h12345678);
    dm_req = 1'b0; mem_ready = 1'b0;
    tick();

    // ---------------- flush during a fetch with three wait states ----------------
    if_req = 1'b1; if_addr = 32'h8;
    tick();
    check("fl_req1", mem_req, 32'd1);
    tick();
    if_flush = 1'b1; if_req = 1'b0;
    tick();
    if_flush = 1'b0;
    check("fl_req3", mem_req, 32'd1);
    tick();
    check("fl_req4", mem_req, 32'd1);
    check("fl_no_err", bus_err, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h55555555;
    tick();
    check("fl_no_valid", if_valid, 32'd0);
    check("fl_req_drop", mem_req, 32'd0);
    check("fl_rdata_kept", if_rdata, 32'hAAAA5555);
    mem_ready = 1'b0;
    tick();
    check("fl_no_valid2", if_valid, 32'd0);
    check("fl_idle", mem_req, 32'd0);

    // ---------------- flush and mem_ready in the same cycle ----------------
    if_req = 1'b1; if_addr = 32'h20;
    tick();
    if_req = 1'b0; if_flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h66666666;
    tick();
    if_flush = 1'b0; mem_ready = 1'b0;
    check("fr_no_valid", if_valid, 32'd0);
    check("fr_req_drop", mem_req, 32'd0);

    // ---------------- timeout on a load ----------------
    dm_req = 1'b1; dm_addr = 32'h300; mem_rdata = 32'hFFFFFFFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t_mem_req_hold", mem_req, 32'd1);
      check("t_no_err", bus_err, 32'd0);
      tick();
    end
    check("t_mem_req_drop", mem_req, 32'd0);
    check("t_bus_err", bus_err, 32'd1);
    check("t_dm_done", dm_done, 32'd1);
    check("t_dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    tick();
    check("t_bus_err_one", bus_err, 32'd0);
    check("t_dm_done_one", dm_done, 32'd0);

    // ---------------- reset in the middle of a data access ----------------
    dm_req = 1'b1; dm_addr = 32'h500;
    tick();
    check("r_mem_req", mem_req, 32'd1);
    #2 reset = 1'b1; dm_req = 1'b0;
    #1 check("r_async_drop", mem_req, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h77777777;
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    check("r_no_done", dm_done, 32'd0);
    check("r_first_grant", mem_req, 32'd1);
    check("r_first_addr", mem_addr, 32'h10);
    mem_ready = 1'b1; mem_rdata = 32'h88888888;
    tick();
    check("r_if_valid", if_valid, 32'd1);
    check("r_no_done2", dm_done, 32'd0);
    if_req = 1'b0; mem_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
